// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
// FSM state encodings and the register-address width default live here.
// Performance counters in pipe_hazard_ctrl are enabled by defining
// YSYX_25060170_PERF_CNT_EN at compile time.
package pipe_hazard_ctrl_pkg;

    localparam int REGADDR_W_DEF = 5;

    // Controller FSM states; encoding 2'd3 is illegal and recovers to RUN
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_TRAP  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Load-use hazard detector: EX holds a load whose destination is read by ID.
module hazard_lu_detect #(
    parameter int REGADDR_W = 5
) (
    input  logic                 ex_load_flag,
    input  logic                 ex_rd_ena,
    input  logic [REGADDR_W-1:0] ex_rd_addr,
    input  logic [REGADDR_W-1:0] id_rs1_addr,
    input  logic [REGADDR_W-1:0] id_rs2_addr,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    output logic                 load_use
);

    // x0 never carries a dependency, so it is excluded from the match
    always_comb begin
        load_use = ex_load_flag && ex_rd_ena && (ex_rd_addr != '0) &&
                   ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                    (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the IF/ID/EX/LS/WB pipeline.
// Fixed priority: trap > memory wait > multi-cycle EX > redirect >
// load-use / CSR drain. Outputs are combinational (zero-latency stalls).
// Define YSYX_25060170_PERF_CNT_EN to add saturating performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REGADDR_W      = REGADDR_W_DEF,
    parameter int TRAP_FLUSH_CYC = 2,
    parameter int PERF_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REGADDR_W-1:0] id_rs1_addr,
    input  logic [REGADDR_W-1:0] id_rs2_addr,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 id_csr_ena,
    input  logic                 ex_load_flag,
    input  logic                 ex_rd_ena,
    input  logic [REGADDR_W-1:0] ex_rd_addr,
    input  logic                 ex_busy,
    input  logic                 ex_redirect,
    input  logic                 ls_busy,
    input  logic                 ls_trap,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 ifid_flush,
    output logic                 idex_stall,
    output logic                 idex_flush,
    output logic                 exls_stall,
    output logic                 exls_flush,
    output logic                 lswb_flush,
`ifdef YSYX_25060170_PERF_CNT_EN
    output logic [PERF_W-1:0]    perf_lu_cnt,
    output logic [PERF_W-1:0]    perf_mem_cnt,
    output logic [PERF_W-1:0]    perf_flush_cnt,
`endif
    output logic [1:0]           ctrl_state
);

    logic [1:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       ex_v, ls_v, wb_v;
    logic       load_use, csr_wait;
    logic       lu_cyc, mem_cyc, flush_cyc;

    hazard_lu_detect #(
        .REGADDR_W (REGADDR_W)
    ) u_lu (
        .ex_load_flag (ex_load_flag),
        .ex_rd_ena    (ex_rd_ena),
        .ex_rd_addr   (ex_rd_addr),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .load_use     (load_use)
    );

    assign csr_wait   = id_valid && id_csr_ena && (ex_v || ls_v || wb_v);
    assign ctrl_state = rst ? ST_RUN : state;

    // Priority resolution of stall/flush controls and next FSM state
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_stall = 1'b0;
        idex_flush = 1'b0;
        exls_stall = 1'b0;
        exls_flush = 1'b0;
        lswb_flush = 1'b0;
        lu_cyc     = 1'b0;
        mem_cyc    = 1'b0;
        flush_cyc  = 1'b0;
        cnt_nxt    = cnt;
        state_nxt  = (state == ST_DRAIN) ? ST_DRAIN : ST_RUN;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exls_flush = 1'b1;
            lswb_flush = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = ST_RUN;
        end else if ((state == ST_TRAP) || ls_trap) begin
            // cnt holds the TRAP cycles still to come after this one
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exls_flush = 1'b1;
            flush_cyc  = 1'b1;
            if (ls_trap)
                cnt_nxt = 4'(TRAP_FLUSH_CYC - 1);
            else if (cnt != '0)
                cnt_nxt = cnt - 4'd1;
            state_nxt = (cnt_nxt != '0) ? ST_TRAP : ST_RUN;
        end else if (ls_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exls_stall = 1'b1;
            lswb_flush = 1'b1;
            mem_cyc    = 1'b1;
        end else if (ex_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exls_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_cyc  = 1'b1;
            state_nxt  = ST_RUN;
        end else if (load_use || csr_wait) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            lu_cyc     = load_use;
            state_nxt  = csr_wait ? ST_DRAIN : ST_RUN;
        end else begin
            state_nxt  = ST_RUN;
        end
    end

    // FSM, trap counter and back-end occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
            ex_v  <= 1'b0;
            ls_v  <= 1'b0;
            wb_v  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!idex_stall)
                ex_v <= id_valid && !idex_flush;
            if (!exls_stall)
                ls_v <= ex_v && !exls_flush;
            wb_v <= ls_v && !lswb_flush;
        end
    end

`ifdef YSYX_25060170_PERF_CNT_EN
    // Saturating counters of load-use stall, memory stall and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_cnt    <= '0;
            perf_mem_cnt   <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (lu_cyc && (perf_lu_cnt != '1))
                perf_lu_cnt <= perf_lu_cnt + 1'b1;
            if (mem_cyc && (perf_mem_cnt != '1))
                perf_mem_cnt <= perf_mem_cnt + 1'b1;
            if (flush_cyc && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
    logic perf_unused;
    assign perf_unused = lu_cyc ^ mem_cyc ^ flush_cyc ^ (PERF_W != 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized cycles, all compared against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int RW  = 5;
    localparam int TFC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs1_used, id_rs2_used, id_csr_ena;
    logic [RW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          ex_load_flag, ex_rd_ena, ex_busy, ex_redirect;
    logic          ls_busy, ls_trap;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exls_stall, exls_flush, lswb_flush;
    logic [1:0]    ctrl_state;

    int checks = 0;
    int errors = 0;

    // Behavioural model: which back-end stages hold a real instruction,
    // how many trap-flush cycles remain, and whether a CSR is waiting.
    bit occ_ex, occ_ls, occ_wb;
    int trap_left;
    bit drain;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REGADDR_W      (RW),
        .TRAP_FLUSH_CYC (TFC),
        .PERF_W         (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_csr_ena   (id_csr_ena),
        .ex_load_flag (ex_load_flag),
        .ex_rd_ena    (ex_rd_ena),
        .ex_rd_addr   (ex_rd_addr),
        .ex_busy      (ex_busy),
        .ex_redirect  (ex_redirect),
        .ls_busy      (ls_busy),
        .ls_trap      (ls_trap),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_stall   (idex_stall),
        .idex_flush   (idex_flush),
        .exls_stall   (exls_stall),
        .exls_flush   (exls_flush),
        .lswb_flush   (lswb_flush),
        .ctrl_state   (ctrl_state)
    );

    task automatic idle_inputs();
        rst = 0; id_valid = 0; id_rs1_addr = '0; id_rs2_addr = '0;
        id_rs1_used = 0; id_rs2_used = 0; id_csr_ena = 0;
        ex_load_flag = 0; ex_rd_ena = 0; ex_rd_addr = '0;
        ex_busy = 0; ex_redirect = 0; ls_busy = 0; ls_trap = 0;
    endtask

    // Inputs are already applied (just after negedge). Compare outputs,
    // then advance the model across the rising edge.
    task automatic step(input string tag);
        logic [7:0] exp, obs;
        logic [1:0] exp_st;
        bit lu, csr_w, trap;
        #1;
        lu = ex_load_flag && ex_rd_ena && (ex_rd_addr != 0) &&
             ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_used && id_rs2_addr == ex_rd_addr));
        csr_w = id_valid && id_csr_ena && (occ_ex || occ_ls || occ_wb);
        trap  = (trap_left > 0) || ls_trap;
        exp_st = (trap_left > 0) ? 2'd2 : (drain ? 2'd1 : 2'd0);
        // bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush
        //            exls_stall exls_flush lswb_flush
        if (rst)              begin exp = 8'b0010_1011; exp_st = 2'd0; end
        else if (trap)        exp = 8'b0010_1010;
        else if (ls_busy)     exp = 8'b1101_0101;
        else if (ex_busy)     exp = 8'b1101_0010;
        else if (ex_redirect) exp = 8'b0010_1000;
        else if (lu || csr_w) exp = 8'b1100_1000;
        else                  exp = 8'b0000_0000;
        obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exls_stall, exls_flush, lswb_flush};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, exp);
        end
        checks++;
        assert (ctrl_state === exp_st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, ctrl_state, exp_st);
        end
        @(posedge clk);
        if (rst) begin
            occ_ex = 0; occ_ls = 0; occ_wb = 0; trap_left = 0; drain = 0;
        end else begin
            occ_wb = occ_ls && !exp[0];
            if (!exp[2]) occ_ls = occ_ex && !exp[1];
            if (!exp[4]) occ_ex = id_valid && !exp[3];
            if (trap) begin
                trap_left = ls_trap ? TFC - 1 : trap_left - 1;
                drain = 0;
            end else if (ls_busy || ex_busy) begin
                drain = drain;
            end else if (ex_redirect) begin
                drain = 0;
            end else begin
                drain = csr_w;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        occ_ex = 0; occ_ls = 0; occ_wb = 0; trap_left = 0; drain = 0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 0;
        step("idle");

        // load x5 in EX, ID reads x5 via rs1
        id_valid = 1; id_rs1_addr = 5; id_rs1_used = 1;
        ex_load_flag = 1; ex_rd_ena = 1; ex_rd_addr = 5;
        step("lu_hit");
        ex_load_flag = 0; ex_rd_ena = 0;
        step("lu_after");
        // same shape with rd = x0: no hazard
        ex_load_flag = 1; ex_rd_ena = 1; ex_rd_addr = 0; id_rs1_addr = 0;
        step("lu_x0");
        ex_load_flag = 0; ex_rd_ena = 0;

        // multi-cycle EX for 4 cycles, release on the 5th
        ex_busy = 1;
        for (int i = 0; i < 4; i++) step("ex_busy");
        ex_busy = 0;
        step("ex_release");

        // memory wait and redirect together: memory hold wins
        ls_busy = 1; ex_redirect = 1;
        for (int i = 0; i < 3; i++) step("mem_over_redir");
        ls_busy = 0;
        step("redir_after_mem");
        ex_redirect = 0;

        // fill EX/LS/WB, then a CSR drains the back-end before issuing
        idle_inputs();
        id_valid = 1;
        for (int i = 0; i < 3; i++) step("fill");
        id_csr_ena = 1;
        for (int i = 0; i < 3; i++) step("csr_drain");
        step("csr_issue");
        idle_inputs();
        step("csr_done");

        // trap pulse; ls_busy during the second flush cycle is ignored
        ls_trap = 1;
        step("trap_pulse");
        ls_trap = 0; ls_busy = 1;
        step("trap_hold");
        ls_busy = 0;
        step("trap_exit");

        // reset in the middle of a drain
        id_valid = 1;
        for (int i = 0; i < 3; i++) step("fill2");
        id_csr_ena = 1;
        step("drain_enter");
        step("drain_mid");
        rst = 1;
        step("rst_mid_drain");
        rst = 0;
        step("post_rst");
        idle_inputs();

        // randomized traffic on a small register set to provoke matches
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(63) == 0);
            id_valid     = $urandom_range(1);
            id_rs1_addr  = RW'($urandom_range(3));
            id_rs2_addr  = RW'($urandom_range(3));
            id_rs1_used  = $urandom_range(1);
            id_rs2_used  = $urandom_range(1);
            id_csr_ena   = ($urandom_range(3) == 0);
            ex_load_flag = $urandom_range(1);
            ex_rd_ena    = $urandom_range(1);
            ex_rd_addr   = RW'($urandom_range(3));
            ex_busy      = ($urandom_range(5) == 0);
            ex_redirect  = ($urandom_range(7) == 0);
            ls_busy      = ($urandom_range(5) == 0);
            ls_trap      = ($urandom_range(19) == 0);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
